pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the 6-bit stall vector consumed by PC, IF/ID, ID/EX, EX/MEM, MEM/WB and WB. It sequences exception and eret redirection by generating flush and new_pc. It also watches for runaway stalls.
- Small FSM tracks RUN / STALL / FLUSH.
- Saturating counter measures consecutive stall cycles.

Parameters:
- EXC_ENTRY, 32'h0000_0020, handler entry address for all non-eret exceptions.
- STALL_TIMEOUT, 1024, number of consecutive stall cycles that sets stall_timeout.
- CNT_W, 16, width of the consecutive-stall counter; must satisfy 2^CNT_W > STALL_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_if  in  1  IF stage (instruction fetch wait) requests stall.
- stallreq_id  in  1  ID stage (load-use hazard) requests stall.
- stallreq_ex  in  1  EX stage (div/madd multi-cycle) requests stall.
- stallreq_mem  in  1  MEM stage (data bus wait) requests stall.
- exc_valid  in  1  MEM stage reports an accepted exception or eret this cycle.
- exc_eret  in  1  qualifies exc_valid: 1 = eret, 0 = exception.
- cp0_epc  in  32  current EPC, used as the eret target.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = stop.
- flush  out  1  clears all pipeline registers and redirects PC.
- new_pc  out  32  redirect target; valid only while flush = 1.
- ctrl_state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
- stall_timeout  out  1  sticky flag; set when a stall reaches STALL_TIMEOUT cycles.

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - state = RUN, counter = 0.
  - stall = 6'b0, flush = 0, new_pc = 0, stall_timeout = 0.
  - Reset mid-stall or mid-flush abandons the operation immediately.
- stall, flush and new_pc are combinational from the inputs and the state, with zero latency, so the pipeline registers act on the same rising edge.
- exc_accept = exc_valid && state != FLUSH.
- Exception handling, when exc_accept = 1:
  - flush = 1 and stall = 0.
  - new_pc = cp0_epc if exc_eret = 1, else EXC_ENTRY.
  - Next state = FLUSH.
  - An exception has priority over every stall request in the same cycle.
- Stall vector when exc_accept = 0, using the deepest active request:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- FLUSH state lasts exactly one cycle:
  - exc_valid is ignored (it belongs to a flushed instruction), so flush = 0.
  - Stall requests are still honoured normally.
  - Next state = STALL if any request is active, else RUN.
- RUN ↔ STALL: next state = STALL while any stall request is active, RUN otherwise.
- Consecutive-stall counter:
  - Increments on every cycle with stall != 0.
  - Clears on any cycle with stall == 0 or flush == 1.
  - Saturates at all-ones.
- When counter == STALL_TIMEOUT-1 and stall is still nonzero, stall_timeout is set on the next edge. It stays set until reset.
- Back-to-back exceptions on consecutive cycles: the second is dropped by design, because FLUSH masks it.
- An exception arriving on the first cycle after FLUSH is accepted normally.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, two 32-bit output ports are added:
  - perf_stall_cnt: cycles with stall != 0.
  - perf_flush_cnt: cycles with flush = 1.
  - Both are free-running, wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package ctrl_pkg holds:
  - stall bit indices and the five stall vector constants;
  - FSM state encodings (RUN/STALL/FLUSH);
  - the EXC_ENTRY default.
- One natural sub-module, stall_watchdog:
  - holds the CNT_W saturating counter and sticky timeout flag;
  - inputs: clk, rst, stall_active, clear;
  - output: timeout.

Test Plan:
- Reset asserted mid-STALL with stallreq_ex = 1 → immediately stall = 0, ctrl_state = 0; after release with requests low, stall stays 0.
- stallreq_id pulse for 3 cycles → stall = 6'b000111 for exactly those 3 cycles, ctrl_state = 1 from the second of them; with stallreq_id and stallreq_mem both high → 6'b011111.
- exc_valid = 1, exc_eret = 0 together with stallreq_mem = 1 → same cycle flush = 1, stall = 0, new_pc = 32'h20; next cycle ctrl_state = 2 and flush = 0.
- exc_valid with exc_eret = 1, cp0_epc = 32'hBFC0_0100 → flush = 1, new_pc = 32'hBFC0_0100; exc_valid held for 2 cycles → second cycle flush = 0; a third-cycle exc_valid is accepted.
- With STALL_TIMEOUT = 8: stallreq_ex held for 7 cycles → stall_timeout = 0; held for 8 cycles → stall_timeout = 1 after the 8th, and it stays 1 after the request drops.
- With PIPE_CTRL_PERF_EN: 5 stall cycles and 2 accepted exceptions → perf_stall_cnt = 5, perf_flush_cnt = 2.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bit positions, stall vectors,
// FSM encodings and the default exception entry address.
package ctrl_pkg;

  localparam int STALL_W    = 6;
  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EXMM = 3;
  localparam int STALL_MMWB = 4;
  localparam int STALL_WB   = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

  // The deepest requesting stage decides how much of the pipe is frozen.
  function automatic logic [STALL_W-1:0] stall_vec(input logic req_mem, input logic req_ex,
                                                   input logic req_id, input logic req_if);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall cycles (saturating) and raises a sticky timeout flag
// once a stall lasts STALL_TIMEOUT cycles.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  input  logic clear,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (clear || !stall_active) begin
        cnt_reg <= '0;
      end else if (cnt_reg != {CNT_W{1'b1}}) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (stall_active && !clear && cnt_reg == CNT_LAST) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout = timeout_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences exception/eret flushes and
// watches for runaway stalls. Define PIPE_CTRL_PERF_EN to add stall/flush perf counters.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY     = EXC_ENTRY_DEFAULT,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               exc_valid,
  input  logic               exc_eret,
  input  logic [31:0]        cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic [1:0]         ctrl_state,
  output logic               stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  ctrl_state_t state_reg;
  logic        any_req;
  logic        exc_accept;

  assign any_req    = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
  // An exception seen during FLUSH belongs to an instruction already being squashed.
  assign exc_accept = exc_valid && (state_reg != ST_FLUSH);

  // Zero-latency outputs so the pipeline registers act on this same edge.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      if (exc_accept) begin
        flush  = 1'b1;
        new_pc = exc_eret ? cp0_epc : EXC_ENTRY;
      end else begin
        stall = stall_vec(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
    end else if (exc_accept) begin
      state_reg <= ST_FLUSH;
    end else if (any_req) begin
      state_reg <= ST_STALL;
    end else begin
      state_reg <= ST_RUN;
    end
  end

  assign ctrl_state = state_reg;

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .stall_active(|stall),
    .clear       (flush),
    .timeout     (stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_reg <= 32'h0;
      perf_flush_reg <= 32'h0;
    end else begin
      if (|stall) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (flush)  perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_reg;
  assign perf_flush_cnt = perf_flush_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STALL_TIMEOUT overridden to 8).
// Perf-counter checks are included when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        exc_valid = 1'b0, exc_eret = 1'b0;
  logic [31:0] cp0_epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_ENTRY    (32'h0000_0020),
    .STALL_TIMEOUT(8),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .exc_valid    (exc_valid),
    .exc_eret     (exc_eret),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ctrl_state   (ctrl_state),
    .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Wait for an edge, then drive inputs; checks follow 1 ns later, mid-cycle.
  task automatic step(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                      input logic ev, input logic er);
    @(posedge clk);
    #1;
    stallreq_if  = r_if;
    stallreq_id  = r_id;
    stallreq_ex  = r_ex;
    stallreq_mem = r_mem;
    exc_valid    = ev;
    exc_eret     = er;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_state", 32'(ctrl_state), 32'h0);
    chk("rst_tmo", 32'(stall_timeout), 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    idle();
    chk("idle_stall", 32'(stall), 32'h0);

    // Three-cycle ID stall
    step(0, 1, 0, 0, 0, 0);
    chk("id1_stall", 32'(stall), 32'h07);
    chk("id1_state", 32'(ctrl_state), 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("id2_stall", 32'(stall), 32'h07);
    chk("id2_state", 32'(ctrl_state), 32'h1);
    step(0, 1, 0, 0, 0, 0);
    chk("id3_stall", 32'(stall), 32'h07);
    chk("id3_state", 32'(ctrl_state), 32'h1);
    idle();
    chk("id_end_stall", 32'(stall), 32'h0);
    chk("id_end_state", 32'(ctrl_state), 32'h1);
    idle();
    chk("run_state", 32'(ctrl_state), 32'h0);

    // Priority among stall requests
    step(0, 1, 0, 1, 0, 0);
    chk("idmem_stall", 32'(stall), 32'h1f);
    step(1, 0, 0, 0, 0, 0);
    chk("if_stall", 32'(stall), 32'h03);
    step(1, 1, 1, 0, 0, 0);
    chk("ex_stall", 32'(stall), 32'h0f);
    idle();
    idle();

    // Exception beats a MEM stall
    step(0, 0, 0, 1, 1, 0);
    chk("exc_flush", 32'(flush), 32'h1);
    chk("exc_stall", 32'(stall), 32'h0);
    chk("exc_newpc", new_pc, 32'h20);
    step(0, 0, 0, 1, 0, 0);
    chk("fl_state", 32'(ctrl_state), 32'h2);
    chk("fl_flush", 32'(flush), 32'h0);
    chk("fl_stall", 32'(stall), 32'h1f);
    idle();
    chk("fl_to_stall", 32'(ctrl_state), 32'h1);
    idle();

    // eret held two cycles, then a third accepted
    cp0_epc = 32'hBFC0_0100;
    step(0, 0, 0, 0, 1, 1);
    chk("eret_flush", 32'(flush), 32'h1);
    chk("eret_newpc", new_pc, 32'hBFC0_0100);
    step(0, 0, 0, 0, 1, 1);
    chk("eret2_state", 32'(ctrl_state), 32'h2);
    chk("eret2_flush", 32'(flush), 32'h0);
    step(0, 0, 0, 0, 1, 0);
    chk("exc3_state", 32'(ctrl_state), 32'h0);
    chk("exc3_flush", 32'(flush), 32'h1);
    chk("exc3_newpc", new_pc, 32'h20);
    idle();
    idle();

    // Reset mid-STALL
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("pre_rst_st", 32'(ctrl_state), 32'h1);
    rst = 1'b0;
    #1;
    chk("mrst_stall", 32'(stall), 32'h0);
    chk("mrst_state", 32'(ctrl_state), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle();
    chk("post_rst_stall", 32'(stall), 32'h0);
    chk("post_rst_state", 32'(ctrl_state), 32'h0);

    // Watchdog: 7 stall cycles is below the limit
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
    idle();
    chk("tmo7", 32'(stall_timeout), 32'h0);
    idle();
    // 8 stall cycles trips it, and it stays set
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
    chk("tmo8_before", 32'(stall_timeout), 32'h0);
    idle();
    chk("tmo8_after", 32'(stall_timeout), 32'h1);
    idle();
    idle();
    chk("tmo_sticky", 32'(stall_timeout), 32'h1);

`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b0;
    #1;
    chk("perf_rst_s", perf_stall_cnt, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0);
    idle();
    step(0, 0, 0, 0, 1, 1);
    idle();
    chk("perf_stall", perf_stall_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
